fetch_decode_unit: RTL and testbench

//  Wishbone (classic) single-transfer memory engine plus instruction field decoder for the 32-bit CPU.
//  On i_enable it performs one bus read or write at i_pc.
//  A read returns the word on o_instruction and pulses o_completed.
//  A completed read is then split into opcode/extra/operandA/operandB/immediate, and o_decoded pulses.
//  The CPU uses it for instruction fetch, and with i_we for load/store.

---
 rtl/fetch_decode_unit.sv | 110 +++++++++++
 tb/tb_fetch_decode_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_unit.sv
// fetch_decode_unit: Wishbone classic single-transfer engine with instruction field decode.
module fetch_decode_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_enable,
   input  logic [ADDR_WIDTH-1:0] i_pc,
   input  logic                  i_we,
   input  logic [DATA_WIDTH-1:0] i_value,
   input  logic [1:0]            i_data_width,
   output logic [DATA_WIDTH-1:0] o_instruction,
   output logic                  o_completed,
   output logic [ADDR_WIDTH-1:0] o_wb_addr,
   output logic [DATA_WIDTH-1:0] o_wb_data,
   output logic                  o_wb_we,
   output logic                  o_wb_cyc,
   output logic                  o_wb_stb,
   output logic [1:0]            o_data_width,
   input  logic                  i_wb_ack,
   input  logic [DATA_WIDTH-1:0] i_wb_data,
   output logic [3:0]            o_opcode,
   output logic [3:0]            o_extra,
   output logic [3:0]            o_operandA,
   output logic [3:0]            o_operandB,
   output logic [15:0]           o_immediate,
   output logic                  o_decoded
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] BUS    = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;
   localparam logic [1:0] DECODE = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic                  we_q, we_d;
   logic [DATA_WIDTH-1:0] value_q, value_d;
   logic [1:0]            width_q, width_d;
   logic [DATA_WIDTH-1:0] instr_q, instr_d;
   logic [DATA_WIDTH-1:0] dec_q, dec_d;
   logic [DATA_WIDTH-1:0] rd_data;

   // Narrow reads are zero-extended from the low lanes; widths 10 and 11 both mean word.
   assign rd_data = (width_q == 2'b00) ? {{(DATA_WIDTH-8){1'b0}}, i_wb_data[7:0]} :
                    (width_q == 2'b01) ? {{(DATA_WIDTH-16){1'b0}}, i_wb_data[15:0]} : i_wb_data;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      we_d    = we_q;
      value_d = value_q;
      width_d = width_q;
      instr_d = instr_q;
      dec_d   = dec_q;
      case (state_q)
         IDLE: if (i_enable) begin
            state_d = BUS;
            pc_d    = i_pc;
            we_d    = i_we;
            value_d = i_value;
            width_d = i_data_width;
         end
         BUS: if (i_wb_ack) begin
            state_d = DONE;
            instr_d = we_q ? instr_q : rd_data;
         end
         DONE: begin
            state_d = we_q ? IDLE : DECODE;
            dec_d   = we_q ? dec_q : instr_q;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         pc_q    <= '0;
         we_q    <= 1'b0;
         value_q <= '0;
         width_q <= 2'b00;
         instr_q <= '0;
         dec_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         we_q    <= we_d;
         value_q <= value_d;
         width_q <= width_d;
         instr_q <= instr_d;
         dec_q   <= dec_d;
      end
   end

   assign o_wb_cyc      = state_q == BUS;
   assign o_wb_stb      = state_q == BUS;
   assign o_wb_we       = (state_q == BUS) && we_q;
   assign o_wb_addr     = pc_q;
   assign o_wb_data     = value_q;
   assign o_data_width  = width_q;
   assign o_completed   = state_q == DONE;
   assign o_decoded     = state_q == DECODE;
   assign o_instruction = instr_q;
   assign o_opcode      = dec_q[31:28];
   assign o_extra       = dec_q[27:24];
   assign o_operandA    = dec_q[23:20];
   assign o_operandB    = dec_q[19:16];
   assign o_immediate   = dec_q[15:0];
endmodule

// File: tb/tb_fetch_decode_unit.sv
// tb_fetch_decode_unit: directed checks of bus timing, read/write, decode and reset behaviour.
module tb_fetch_decode_unit;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        i_enable = 1'b0;
   logic [31:0] i_pc = '0;
   logic        i_we = 1'b0;
   logic [31:0] i_value = '0;
   logic [1:0]  i_data_width = 2'b10;
   logic [31:0] o_instruction;
   logic        o_completed;
   logic [31:0] o_wb_addr;
   logic [31:0] o_wb_data;
   logic        o_wb_we;
   logic        o_wb_cyc;
   logic        o_wb_stb;
   logic [1:0]  o_data_width;
   logic        i_wb_ack = 1'b0;
   logic [31:0] i_wb_data = '0;
   logic [3:0]  o_opcode, o_extra, o_operandA, o_operandB;
   logic [15:0] o_immediate;
   logic        o_decoded;
   int          errors = 0;
   int          checks = 0;

   fetch_decode_unit dut (
      .clk(clk), .reset(reset), .i_enable(i_enable), .i_pc(i_pc), .i_we(i_we),
      .i_value(i_value), .i_data_width(i_data_width), .o_instruction(o_instruction),
      .o_completed(o_completed), .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
      .o_wb_we(o_wb_we), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
      .o_data_width(o_data_width), .i_wb_ack(i_wb_ack), .i_wb_data(i_wb_data),
      .o_opcode(o_opcode), .o_extra(o_extra), .o_operandA(o_operandA),
      .o_operandB(o_operandB), .o_immediate(o_immediate), .o_decoded(o_decoded)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [127:0] all_out;
      reset = 1'b0;
      i_enable = 1'b1;
      i_pc = 32'h1234_5678;
      i_wb_ack = 1'b1;
      i_wb_data = 32'hFFFF_FFFF;
      step();
      step();
      all_out = {o_instruction, o_wb_addr, o_wb_data, o_completed, o_wb_we, o_wb_cyc, o_wb_stb,
                 o_data_width, o_opcode, o_extra, o_operandA, o_operandB, o_immediate, o_decoded};
      checks++;
      if (all_out !== '0) begin
         errors++;
         $display("FAIL reset_outputs got %h want 0", all_out);
      end
      i_enable = 1'b0;
      i_wb_ack = 1'b0;
      reset = 1'b1;
      step();
      checks++;
      if (o_wb_cyc !== 1'b0) begin
         errors++;
         $display("FAIL reset_enable_ignored cyc=%b want 0", o_wb_cyc);
      end
   endtask

   task automatic test_read();
      i_pc = 32'hB000_0000;
      i_we = 1'b0;
      i_data_width = 2'b10;
      i_enable = 1'b1;
      step();
      i_enable = 1'b0;
      checks++;
      if ({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr} !== {3'b110, 32'hB000_0000}) begin
         errors++;
         $display("FAIL read_bus cyc/stb/we=%b%b%b addr=%h want 110 b0000000", o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr);
      end
      i_wb_ack = 1'b1;
      i_wb_data = 32'h4123_4ABC;
      step();
      i_wb_ack = 1'b0;
      i_wb_data = '0;
      checks++;
      if ({o_completed, o_wb_cyc, o_decoded} !== 3'b100 || o_instruction !== 32'h4123_4ABC) begin
         errors++;
         $display("FAIL read_done comp/cyc/dec=%b%b%b instr=%h want 100 41234abc", o_completed, o_wb_cyc, o_decoded, o_instruction);
      end
      step();
      checks++;
      if ({o_decoded, o_completed, o_opcode, o_extra, o_operandA, o_operandB, o_immediate} !== {2'b10, 32'h4123_4ABC}) begin
         errors++;
         $display("FAIL read_decode dec/comp=%b%b fields=%h %h %h %h %h want 10 4 1 2 3 4abc",
                  o_decoded, o_completed, o_opcode, o_extra, o_operandA, o_operandB, o_immediate);
      end
      step();
      checks++;
      if ({o_decoded, o_wb_cyc} !== 2'b00 || o_immediate !== 16'h4ABC || o_instruction !== 32'h4123_4ABC) begin
         errors++;
         $display("FAIL read_hold dec/cyc=%b%b imm=%h instr=%h want 00 4abc 41234abc", o_decoded, o_wb_cyc, o_immediate, o_instruction);
      end
   endtask

   task automatic test_write();
      int comp_cnt = 0;
      int dec_cnt = 0;
      i_pc = 32'hB000_FFFC;
      i_we = 1'b1;
      i_value = 32'hDEAD_BEEF;
      i_data_width = 2'b10;
      i_enable = 1'b1;
      step();
      i_enable = 1'b0;
      i_pc = '0;
      i_value = '0;
      i_we = 1'b0;
      for (int w = 0; w < 4; w++) begin
         checks++;
         if ({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data} !== {3'b111, 32'hB000_FFFC, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL write_stable[%0d] cyc/stb/we=%b%b%b addr=%h data=%h want 111 b000fffc deadbeef",
                     w, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data);
         end
         i_wb_ack = (w == 3);
         step();
      end
      i_wb_ack = 1'b0;
      checks++;
      if ({o_completed, o_wb_cyc, o_wb_we} !== 3'b100) begin
         errors++;
         $display("FAIL write_done comp/cyc/we=%b%b%b want 100", o_completed, o_wb_cyc, o_wb_we);
      end
      for (int c = 0; c < 4; c++) begin
         comp_cnt += int'(o_completed);
         dec_cnt += int'(o_decoded);
         step();
      end
      checks++;
      if (comp_cnt !== 1 || dec_cnt !== 0 || o_instruction !== 32'h4123_4ABC) begin
         errors++;
         $display("FAIL write_pulses completed=%0d decoded=%0d instr=%h want 1 0 41234abc", comp_cnt, dec_cnt, o_instruction);
      end
   endtask

   task automatic test_enable_in_bus();
      int comp_cnt = 0;
      int cyc_rises = 0;
      logic prev_cyc = 1'b0;
      i_pc = 32'h0000_0100;
      i_we = 1'b0;
      i_data_width = 2'b10;
      i_enable = 1'b1;
      step();
      for (int c = 0; c < 8; c++) begin
         i_enable = (c < 2);
         i_wb_ack = (c == 2);
         i_wb_data = 32'h1111_2222;
         cyc_rises += int'(o_wb_cyc && !prev_cyc);
         comp_cnt += int'(o_completed);
         prev_cyc = o_wb_cyc;
         step();
      end
      i_wb_ack = 1'b0;
      checks++;
      if (cyc_rises !== 1 || comp_cnt !== 1) begin
         errors++;
         $display("FAIL enable_in_bus cycles=%0d completed=%0d want 1 1", cyc_rises, comp_cnt);
      end
   endtask

   task automatic test_narrow_read(input logic [1:0] width, input logic [31:0] exp, input string name);
      i_pc = 32'h0000_0203;
      i_we = 1'b0;
      i_data_width = width;
      i_enable = 1'b1;
      step();
      i_enable = 1'b0;
      i_data_width = 2'b10;
      checks++;
      if (o_data_width !== width || o_wb_cyc !== 1'b1) begin
         errors++;
         $display("FAIL %s_width width=%b cyc=%b want %b 1", name, o_data_width, o_wb_cyc, width);
      end
      i_wb_ack = 1'b1;
      i_wb_data = 32'hAABB_CCDD;
      step();
      i_wb_ack = 1'b0;
      checks++;
      if (o_instruction !== exp || o_completed !== 1'b1) begin
         errors++;
         $display("FAIL %s_read instr=%h comp=%b want %h 1", name, o_instruction, o_completed, exp);
      end
      step();
      step();
   endtask

   task automatic test_reset_mid_bus();
      int comp_cnt = 0;
      i_pc = 32'h0000_0400;
      i_we = 1'b0;
      i_data_width = 2'b10;
      i_enable = 1'b1;
      step();
      i_enable = 1'b0;
      reset = 1'b0;
      step();
      reset = 1'b1;
      checks++;
      if ({o_wb_cyc, o_wb_stb, o_completed} !== 3'b000) begin
         errors++;
         $display("FAIL reset_mid_bus cyc/stb/comp=%b%b%b want 000", o_wb_cyc, o_wb_stb, o_completed);
      end
      i_wb_ack = 1'b1;
      i_wb_data = 32'h7777_7777;
      for (int c = 0; c < 3; c++) begin
         comp_cnt += int'(o_completed) + int'(o_wb_cyc);
         step();
      end
      i_wb_ack = 1'b0;
      checks++;
      if (comp_cnt !== 0) begin
         errors++;
         $display("FAIL reset_no_completion events=%0d want 0", comp_cnt);
      end
      i_pc = 32'h0000_0800;
      i_enable = 1'b1;
      step();
      i_enable = 1'b0;
      i_wb_ack = 1'b1;
      i_wb_data = 32'h5678_9ABC;
      step();
      i_wb_ack = 1'b0;
      checks++;
      if (o_completed !== 1'b1 || o_instruction !== 32'h5678_9ABC) begin
         errors++;
         $display("FAIL after_reset_read comp=%b instr=%h want 1 56789abc", o_completed, o_instruction);
      end
      step();
      checks++;
      if (o_decoded !== 1'b1 || o_opcode !== 4'h5 || o_immediate !== 16'h9ABC) begin
         errors++;
         $display("FAIL after_reset_decode dec=%b op=%h imm=%h want 1 5 9abc", o_decoded, o_opcode, o_immediate);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_enable_in_bus();
      test_narrow_read(2'b00, 32'h0000_00DD, "byte");
      test_narrow_read(2'b01, 32'h0000_CCDD, "half");
      test_reset_mid_bus();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
